// File: rtl/fpu_pkg.sv
// Shared encodings for the single-precision FPU front-end: OP-FP decode fields,
// core opcode codes and the PCPI controller state type.
package fpu_pkg;

  localparam logic [6:0] OPCODE_OP_FP = 7'b1010011;
  localparam logic [1:0] FMT_S        = 2'b00;

  localparam logic [6:0] FUNCT7_FADD = 7'b0000000;
  localparam logic [6:0] FUNCT7_FSUB = 7'b0000100;
  localparam logic [6:0] FUNCT7_FMUL = 7'b0001000;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  localparam logic [31:0] QNAN_S = 32'h7FC00000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    RESPOND,
    DRAIN
  } fpu_state_e;

endpackage

// File: rtl/fpu_pcpi_decode.sv
// Combinational OP-FP decoder: flags supported single-precision instructions
// and maps them to the core opcode. The rounding-mode field is deliberately ignored.
module fpu_pcpi_decode
  import fpu_pkg::*;
(
  input  logic [31:0] inst,
  output logic        match,
  output logic [1:0]  op_code
);

  // Register and rounding-mode fields play no part in the decision.
  logic unused_fields;
  assign unused_fields = ^inst[24:7];

  always_comb begin
    match   = 1'b0;
    op_code = OP_ADD;
    if (inst[6:0] == OPCODE_OP_FP && inst[26:25] == FMT_S) begin
      case (inst[31:25])
        FUNCT7_FADD: begin
          match   = 1'b1;
          op_code = OP_ADD;
        end
        FUNCT7_FSUB: begin
          match   = 1'b1;
          op_code = OP_SUB;
        end
        FUNCT7_FMUL: begin
          match   = 1'b1;
          op_code = OP_MUL;
        end
        default: begin
          match   = 1'b0;
          op_code = OP_ADD;
        end
      endcase
    end
  end

endmodule

// File: rtl/fpu_pcpi_ctrl.sv
// PCPI front-end for the single-precision FPU: decodes OP-FP instructions, issues
// them to the arithmetic core and returns the result, with a watchdog NaN fallback.
module fpu_pcpi_ctrl
  import fpu_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] QNAN_VALUE     = DATA_WIDTH'(QNAN_S)
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  pcpiValidIn,
  input  logic [31:0]           pcpiInstIn,
  input  logic [DATA_WIDTH-1:0] pcpiRs1In,
  input  logic [DATA_WIDTH-1:0] pcpiRs2In,
  output logic                  pcpiWrOut,
  output logic [DATA_WIDTH-1:0] pcpiRdOut,
  output logic                  pcpiWaitOut,
  output logic                  pcpiReadyOut,
  output logic                  opValidOut,
  output logic [1:0]            opCodeOut,
  output logic [DATA_WIDTH-1:0] opAOut,
  output logic [DATA_WIDTH-1:0] opBOut,
  input  logic                  opReadyIn,
  input  logic                  resValidIn,
  input  logic [DATA_WIDTH-1:0] resDataIn,
  output logic                  opFlushOut,
  output logic                  timeoutOut
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  fpu_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  capture;
  logic                  flush_d;
  logic                  timeout_evt;
  logic                  wait_d;
  logic                  op_valid_d;
  logic                  respond_d;
  logic [DATA_WIDTH-1:0] rd_d;

  logic       dec_match;
  logic [1:0] dec_op;

  fpu_pcpi_decode u_decode (
    .inst    (pcpiInstIn),
    .match   (dec_match),
    .op_code (dec_op)
  );

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Abort beats result, and a result arriving on the last watchdog cycle beats the timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    capture     = 1'b0;
    flush_d     = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (pcpiValidIn && dec_match) begin
          state_d = ISSUE;
          cnt_d   = '0;
          capture = 1'b1;
        end
      end
      ISSUE, WAIT_RES: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!pcpiValidIn) begin
          state_d = IDLE;
          flush_d = 1'b1;
        end else if (state_q == WAIT_RES && resValidIn) begin
          res_d   = resDataIn;
          state_d = RESPOND;
        end else if (cnt_q == CNT_LAST) begin
          res_d       = QNAN_VALUE;
          flush_d     = 1'b1;
          timeout_evt = 1'b1;
          state_d     = RESPOND;
        end else if (state_q == ISSUE && opValidOut && opReadyIn) begin
          state_d = WAIT_RES;
        end
      end
      RESPOND: state_d = DRAIN;
      DRAIN: begin
        if (!pcpiValidIn) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wait_d     = (state_d == ISSUE) || (state_d == WAIT_RES) || (state_d == RESPOND);
    op_valid_d = (state_d == ISSUE);
    respond_d  = (state_q == RESPOND);
    rd_d       = respond_d ? res_q : pcpiRdOut;
  end

  // Every output is a flop so the CPU and core never see decode glitches.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      pcpiWaitOut  <= 1'b0;
      pcpiReadyOut <= 1'b0;
      pcpiWrOut    <= 1'b0;
      pcpiRdOut    <= '0;
      opValidOut   <= 1'b0;
      opCodeOut    <= OP_ADD;
      opAOut       <= '0;
      opBOut       <= '0;
      opFlushOut   <= 1'b0;
      timeoutOut   <= 1'b0;
    end else begin
      pcpiWaitOut  <= wait_d;
      pcpiReadyOut <= respond_d;
      pcpiWrOut    <= respond_d;
      pcpiRdOut    <= rd_d;
      opValidOut   <= op_valid_d;
      opFlushOut   <= flush_d;
      timeoutOut   <= timeoutOut | timeout_evt;
      if (capture) begin
        opAOut    <= pcpiRs1In;
        opBOut    <= pcpiRs2In;
        opCodeOut <= dec_op;
      end
    end
  end

endmodule

// File: doc/fpu_pcpi_ctrl.md
Name: fpu_pcpi_ctrl

Overview:
PCPI front-end for the single-precision FPU. It sits directly downstream of the picorv32 PCPI port and upstream of the FP arithmetic core. It decodes OP-FP instructions (fadd.s, fsub.s, fmul.s) and issues operands to the core over a valid/ready handshake. It returns the core's result to the CPU with the PCPI wait/ready/wr protocol, and a watchdog guarantees a response if the core stalls.

Parameters:
DATA_WIDTH, 32, operand/result width
TIMEOUT_CYCLES, 64, max cycles from issue to result before a forced NaN response (must be >=2)
QNAN_VALUE, 32'h7FC00000, result written on timeout

Ports:
clkIn  in  1  clock
rstIn  in  1  reset; synchronous, active-high
pcpiValidIn  in  1  PCPI instruction valid from CPU
pcpiInstIn  in  32  PCPI instruction word
pcpiRs1In  in  DATA_WIDTH  operand A
pcpiRs2In  in  DATA_WIDTH  operand B
pcpiWrOut  out  1  write rd (pulses with pcpiReadyOut)
pcpiRdOut  out  DATA_WIDTH  result
pcpiWaitOut  out  1  instruction accepted, result pending
pcpiReadyOut  out  1  result valid, one-cycle pulse
opValidOut  out  1  operation request to core
opCodeOut  out  2  0=add, 1=sub, 2=mul
opAOut  out  DATA_WIDTH  captured rs1
opBOut  out  DATA_WIDTH  captured rs2
opReadyIn  in  1  core accepts request
resValidIn  in  1  core result valid (single-cycle)
resDataIn  in  DATA_WIDTH  core result
opFlushOut  out  1  one-cycle pulse: core must drop in-flight op
timeoutOut  out  1  sticky: a watchdog timeout occurred

Behaviour:
- Clock/reset: single clock clkIn. rstIn is synchronous, active-high.
- Reset: all outputs 0, state IDLE, counter 0. Reset mid-operation aborts with no PCPI response.
- Decode match: inst[6:0]==7'b1010011 and inst[26:25]==2'b00. funct7 (inst[31:25]) 0000000=add, 0000100=sub, 0001000=mul. rm ignored. Anything else is not matched and is never acknowledged (CPU raises illegal-instruction).
- All outputs are registered.
- IDLE: pcpiValidIn & match -> capture rs1, rs2 and opcode -> ISSUE. Next cycle pcpiWaitOut=1, opValidOut=1.
- ISSUE: opValidOut held with stable operands until opValidOut&opReadyIn -> WAIT_RES, opValidOut=0 next cycle.
- WAIT_RES: resValidIn -> capture resDataIn -> RESPOND.
- RESPOND (exactly 1 cycle): pcpiReadyOut=1, pcpiWrOut=1, pcpiRdOut=result, pcpiWaitOut=0 -> DRAIN.
- DRAIN: hold until pcpiValidIn==0 -> IDLE. The same instruction is never re-decoded.
- Latency: the first RESPOND cycle is 2 cycles after resValidIn is seen while in WAIT_RES (capture, then registered output). With zero-wait core accept and a 1-cycle core, total is 4 cycles from pcpiValidIn.
- pcpiRdOut retains its last value outside RESPOND. pcpiWrOut/pcpiReadyOut are 0 outside RESPOND.
- Watchdog:
  - Counter clears on IDLE->ISSUE and increments each cycle in ISSUE/WAIT_RES.
  - At count==TIMEOUT_CYCLES-1 without result: opFlushOut pulses, timeoutOut sets, result=QNAN_VALUE -> RESPOND.
  - If resValidIn arrives in that same cycle, the real result wins: no flush, no timeout.
- resValidIn outside WAIT_RES is ignored.
- pcpiValidIn falls during ISSUE/WAIT_RES: opFlushOut pulses, opValidOut=0, no response -> IDLE.
- pcpiWaitOut must rise within 1 cycle of a matched pcpiValidIn. This is well within the CPU's 16-cycle PCPI timeout.

Decomposition:
- Package fpu_pkg:
  - OPCODE_OP_FP, FMT_S, FUNCT7_FADD/FSUB/FMUL
  - OP_ADD/OP_SUB/OP_MUL 2-bit codes
  - QNAN_S constant
  - state enum {IDLE, ISSUE, WAIT_RES, RESPOND, DRAIN}
- One combinational sub-module, fpu_pcpi_decode: instruction in -> match, opCode. It is shared with future FP instruction additions.
- Watchdog counter stays inline.

Test Plan:
- fadd: pcpiInstIn=0x00310253, rs1=0x3F800000, rs2=0x40000000; stub core ready immediately, returns 0x40400000 after 3 cycles -> opCodeOut=0, opA/opB match inputs, pcpiRdOut=0x40400000, single-cycle ready+wr, wait high from cycle 1 until RESPOND.
- fsub/fmul: 0x08310253 -> opCodeOut=1; 0x10310253 with 0x40400000*0x40000000, core returns 0x40C00000 -> pcpiRdOut=0x40C00000.
- Backpressure: opReadyIn low 5 cycles -> opValidOut and operands stable all 5 cycles, exactly one handshake, correct result returned.
- Unsupported: pcpiInstIn=0x00000013 held 20 cycles -> pcpiWaitOut, pcpiReadyOut and opValidOut stay 0.
- Timeout (TIMEOUT_CYCLES=16): core never asserts resValidIn -> opFlushOut pulse, pcpiRdOut=0x7FC00000 with ready+wr, timeoutOut=1 until rstIn. A variant with resValidIn on the final count cycle returns core data, timeoutOut=0.
- Reset/abort: rstIn high in WAIT_RES -> all outputs 0 next cycle, no ready pulse. A pcpiValidIn drop in WAIT_RES -> flush pulse, no ready, next fadd completes correctly.
